// File: rtl/wb_bus_arbiter_if.sv
// Bus-side signals of the round-robin Wishbone master arbiter.
// Requests, muxed strobe and termination come in; grant, hold-ack and watchdog status go out.
interface wb_bus_arbiter_if #(
    parameter int MASTERS   = 4,
    parameter int CNT_WIDTH = 8
);
    logic [MASTERS-1:0]   m_cyc_i;
    logic                 bus_stb_i;
    logic                 bus_ack_i;
    logic                 bus_err_i;
    logic                 bus_rty_i;
    logic                 bus_hold;
    logic [MASTERS-1:0]   grant_o;
    logic                 grant_valid_o;
    logic                 bus_hold_ack;
    logic                 timeout_o;
    logic [CNT_WIDTH-1:0] timeout_cnt_o;
    logic [1:0]           state_o;

    modport slave (
        input  m_cyc_i, bus_stb_i, bus_ack_i, bus_err_i, bus_rty_i, bus_hold,
        output grant_o, grant_valid_o, bus_hold_ack, timeout_o, timeout_cnt_o, state_o
    );

    modport master (
        output m_cyc_i, bus_stb_i, bus_ack_i, bus_err_i, bus_rty_i, bus_hold,
        input  grant_o, grant_valid_o, bus_hold_ack, timeout_o, timeout_cnt_o, state_o
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone master arbiter with exclusive bus hold and a stalled-transfer watchdog.
// Handshake: a master raises m_cyc and keeps it until done; its grant stays frozen while cyc is high.
module wb_bus_arbiter #(
    parameter int MASTERS   = 4,
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    wb_bus_arbiter_if.slave  bus
);
    localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam logic [IDX_W:0] M_EXT = (IDX_W+1)'(MASTERS);
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

    state_t               r_state;
    logic [MASTERS-1:0]   r_grant;
    logic                 r_grant_valid;
    logic                 r_hold_ack;
    logic                 r_timeout;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [IDX_W-1:0]     r_last;

    logic                 w_pick_valid;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [MASTERS-1:0]   w_pick_oh;
    logic                 w_stall;

    // Search starts just after the last winner, so the previous owner ranks lowest.
    always_comb begin : pick_blk
        logic [IDX_W:0] idx;
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_pick_oh    = '0;
        idx          = '0;
        for (int k = 1; k <= MASTERS; k++) begin
            idx = {1'b0, r_last} + (IDX_W+1)'(k);
            if (idx >= M_EXT) idx = idx - M_EXT;
            if (!w_pick_valid && bus.m_cyc_i[idx[IDX_W-1:0]]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = idx[IDX_W-1:0];
            end
        end
        if (w_pick_valid) w_pick_oh[w_pick_idx] = 1'b1;
    end

    assign w_stall = bus.bus_stb_i & ~(bus.bus_ack_i | bus.bus_err_i | bus.bus_rty_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_hold_ack    <= 1'b0;
            r_timeout     <= 1'b0;
            r_cnt         <= '0;
            r_last        <= IDX_W'(MASTERS - 1);
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (bus.bus_hold) begin
                        r_state    <= S_HOLD;
                        r_hold_ack <= 1'b1;
                    end else if (w_pick_valid) begin
                        r_state       <= S_BUSY;
                        r_grant       <= w_pick_oh;
                        r_grant_valid <= 1'b1;
                        r_last        <= w_pick_idx;
                    end
                end
                S_BUSY: begin
                    // r_last always names the current owner while BUSY.
                    if (bus.m_cyc_i[r_last]) begin
                        if (WD_EN && w_stall) begin
                            if (r_cnt == TO_LAST) begin
                                r_timeout <= 1'b1;
                                r_cnt     <= '0;
                            end else if (r_cnt != '1) begin
                                r_cnt <= r_cnt + CNT_WIDTH'(1);
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end else begin
                        r_cnt <= '0;
                        if (bus.bus_hold) begin
                            r_state       <= S_HOLD;
                            r_grant       <= '0;
                            r_grant_valid <= 1'b0;
                            r_hold_ack    <= 1'b1;
                        end else if (w_pick_valid) begin
                            r_grant <= w_pick_oh;
                            r_last  <= w_pick_idx;
                        end else begin
                            r_state       <= S_IDLE;
                            r_grant       <= '0;
                            r_grant_valid <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    r_cnt <= '0;
                    if (!bus.bus_hold) begin
                        r_state    <= S_IDLE;
                        r_hold_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                    r_hold_ack    <= 1'b0;
                    r_cnt         <= '0;
                end
            endcase
        end
    end

    assign bus.grant_o       = r_grant;
    assign bus.grant_valid_o = r_grant_valid;
    assign bus.bus_hold_ack  = r_hold_ack;
    assign bus.timeout_o     = r_timeout;
    assign bus.timeout_cnt_o = r_cnt;
    assign bus.state_o       = r_state;
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: two instances (watchdog TIMEOUT=4 and disabled) share one stimulus,
// checked every cycle against a rule-level model plus directed literal expectations.
module tb_wb_bus_arbiter;
    localparam int MASTERS = 4;
    localparam int TO_A    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] m_cyc = '0;
    logic       stb = 1'b0, ack = 1'b0, err = 1'b0, rty = 1'b0, hold = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter_if #(.MASTERS(MASTERS), .CNT_WIDTH(8)) if_a ();
    wb_bus_arbiter_if #(.MASTERS(MASTERS), .CNT_WIDTH(8)) if_b ();

    assign if_a.m_cyc_i = m_cyc;  assign if_b.m_cyc_i = m_cyc;
    assign if_a.bus_stb_i = stb;  assign if_b.bus_stb_i = stb;
    assign if_a.bus_ack_i = ack;  assign if_b.bus_ack_i = ack;
    assign if_a.bus_err_i = err;  assign if_b.bus_err_i = err;
    assign if_a.bus_rty_i = rty;  assign if_b.bus_rty_i = rty;
    assign if_a.bus_hold = hold;  assign if_b.bus_hold = hold;

    wb_bus_arbiter #(.MASTERS(MASTERS), .TIMEOUT(TO_A), .CNT_WIDTH(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(if_a)
    );
    wb_bus_arbiter #(.MASTERS(MASTERS), .TIMEOUT(0), .CNT_WIDTH(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(if_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: who owns the bus (-1 none), whether the holder owns it, stall run length.
    int m_owner = -1;
    int m_last  = MASTERS - 1;
    bit m_held  = 1'b0;
    int m_run   = 0;
    bit m_to    = 1'b0;

    function automatic int rr_pick(input int last, input logic [3:0] req);
        for (int k = 1; k <= MASTERS; k++)
            if (req[(last + k) % MASTERS]) return (last + k) % MASTERS;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_last = MASTERS - 1; m_held = 1'b0; m_run = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_held) begin
                if (!hold) m_held = 1'b0;
            end else if (m_owner < 0) begin
                if (hold) m_held = 1'b1;
                else if (m_cyc != 0) begin m_owner = rr_pick(m_last, m_cyc); m_last = m_owner; end
            end else if (m_cyc[m_owner]) begin
                if (stb && !ack && !err && !rty) begin
                    m_run++;
                    if (m_run == TO_A) begin m_to = 1'b1; m_run = 0; end
                end else m_run = 0;
            end else begin
                m_run = 0;
                if (hold) begin m_owner = -1; m_held = 1'b1; end
                else if (m_cyc != 0) begin m_owner = rr_pick(m_last, m_cyc); m_last = m_owner; end
                else m_owner = -1;
            end
        end
    end

    always @(posedge clk) begin
        logic [3:0] eg;
        #1;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk("mdl_grant_a", 32'(if_a.grant_o), 32'(eg));
        chk("mdl_gvalid_a", 32'(if_a.grant_valid_o), 32'(m_owner >= 0));
        chk("mdl_hold_ack_a", 32'(if_a.bus_hold_ack), 32'(m_held));
        chk("mdl_timeout_a", 32'(if_a.timeout_o), 32'(m_to));
        chk("mdl_cnt_a", 32'(if_a.timeout_cnt_o), 32'(m_run));
        chk("mdl_grant_b", 32'(if_b.grant_o), 32'(eg));
        chk("mdl_hold_ack_b", 32'(if_b.bus_hold_ack), 32'(m_held));
        chk("mdl_timeout_b", 32'(if_b.timeout_o), 32'(0));
        chk("mdl_cnt_b", 32'(if_b.timeout_cnt_o), 32'(0));
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nxt();
        rst_n = 1'b0;
        m_cyc = '0; stb = 0; ack = 0; err = 0; rty = 0; hold = 0;
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_q[$];
        do_reset();
        chk("rst_grant", 32'(if_a.grant_o), 32'h0);
        chk("rst_gvalid", 32'(if_a.grant_valid_o), 32'h0);
        chk("rst_hold_ack", 32'(if_a.bus_hold_ack), 32'h0);
        chk("rst_cnt", 32'(if_a.timeout_cnt_o), 32'h0);

        // Basic pick and back-to-back handoff.
        m_cyc = 4'b0110;
        nxt(); chk("t1_first", 32'(if_a.grant_o), 32'h2);
        m_cyc = 4'b0100;
        nxt(); chk("t1_handoff", 32'(if_a.grant_o), 32'h4);
        chk("t1_gvalid", 32'(if_a.grant_valid_o), 32'h1);
        m_cyc = 4'b0000;
        nxt(); chk("t1_idle", 32'(if_a.grant_o), 32'h0);

        // Full rotation, each master holding for three cycles then re-requesting.
        do_reset();
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        m_cyc = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk("t2_rot", 32'(if_a.grant_o), 32'(exp_q[i]));
            m_cyc = 4'b1111;
            if (i == 4) break;
            nxt(); nxt();
            m_cyc[i % 4] = 1'b0;
        end
        m_cyc = '0;
        nxt(); nxt();

        // Hold waits for the current owner to finish.
        m_cyc = 4'b0100;
        nxt(); chk("t3_grant", 32'(if_a.grant_o), 32'h4);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("t3_no_ack", 32'(if_a.bus_hold_ack), 32'h0);
            chk("t3_frozen", 32'(if_a.grant_o), 32'h4);
        end
        m_cyc = 4'b0000;
        nxt(); chk("t3_ack", 32'(if_a.bus_hold_ack), 32'h1);
        chk("t3_grant0", 32'(if_a.grant_o), 32'h0);
        hold = 1'b0;
        nxt(); chk("t3_release", 32'(if_a.bus_hold_ack), 32'h0);

        // Hold beats a pending request in IDLE; the request is served after release.
        hold = 1'b1; m_cyc = 4'b0001;
        nxt(); chk("t3b_ack", 32'(if_a.bus_hold_ack), 32'h1);
        chk("t3b_grant0", 32'(if_a.grant_o), 32'h0);
        hold = 1'b0;
        nxt(); chk("t3b_noack", 32'(if_a.bus_hold_ack), 32'h0);
        chk("t3b_still0", 32'(if_a.grant_o), 32'h0);
        nxt(); chk("t3b_grant", 32'(if_a.grant_o), 32'h1);
        m_cyc = 4'b0000;
        nxt();

        // Watchdog fires four cycles into a stall.
        m_cyc = 4'b1000;
        nxt(); chk("t4_grant", 32'(if_a.grant_o), 32'h8);
        stb = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            nxt(); chk("t4_cnt", 32'(if_a.timeout_cnt_o), 32'(i));
            chk("t4_no_to", 32'(if_a.timeout_o), 32'h0);
        end
        nxt(); chk("t4_pulse", 32'(if_a.timeout_o), 32'h1);
        chk("t4_cnt0", 32'(if_a.timeout_cnt_o), 32'h0);
        chk("t4_kept", 32'(if_a.grant_o), 32'h8);
        chk("t4_b_quiet", 32'(if_b.timeout_o), 32'h0);
        nxt(); chk("t4_one_cycle", 32'(if_a.timeout_o), 32'h0);
        chk("t4_restart", 32'(if_a.timeout_cnt_o), 32'h1);
        stb = 1'b0; m_cyc = 4'b0000;
        nxt(); chk("t4_end", 32'(if_a.grant_o), 32'h0);

        // Ack at the threshold wins; cyc drop at the threshold suppresses the pulse.
        m_cyc = 4'b0010;
        nxt(); chk("t5_grant", 32'(if_a.grant_o), 32'h2);
        stb = 1'b1;
        nxt(); nxt(); nxt();
        chk("t5_cnt3", 32'(if_a.timeout_cnt_o), 32'h3);
        ack = 1'b1;
        nxt(); chk("t5_ack_to", 32'(if_a.timeout_o), 32'h0);
        chk("t5_ack_cnt", 32'(if_a.timeout_cnt_o), 32'h0);
        ack = 1'b0;
        nxt(); nxt(); nxt();
        chk("t5_cnt3b", 32'(if_a.timeout_cnt_o), 32'h3);
        m_cyc = 4'b0000;
        nxt(); chk("t5_drop_to", 32'(if_a.timeout_o), 32'h0);
        chk("t5_drop_grant", 32'(if_a.grant_o), 32'h0);
        stb = 1'b0;
        nxt();

        // Long stall: the disabled watchdog never fires.
        m_cyc = 4'b0001; stb = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            nxt();
            chk("t5_b_never", 32'(if_b.timeout_o), 32'h0);
        end
        stb = 1'b0;

        // Asynchronous reset mid-transfer.
        #2 rst_n = 1'b0;
        #1 chk("t6_async_grant", 32'(if_a.grant_o), 32'h0);
        chk("t6_async_gvalid", 32'(if_a.grant_valid_o), 32'h0);
        m_cyc = 4'b0000;
        nxt(); nxt();
        rst_n = 1'b1;
        m_cyc = 4'b1000;
        nxt(); chk("t6_after", 32'(if_a.grant_o), 32'h8);
        m_cyc = 4'b0000;
        nxt(); nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
